// File: rtl/ubitz_dock_cfg_pkg.sv
// rtl/ubitz_dock_cfg_pkg.sv - shared addr_decoder cfg map: byte count, region offsets, op codes
package ubitz_dock_cfg_pkg;

  localparam int         DEF_ADDR_W   = 32;
  localparam logic [7:0] IRQ_CFG_BASE = 8'hC0;

  localparam logic [7:0] OP_RW = 8'hFF;
  localparam logic [7:0] OP_WO = 8'h00;
  localparam logic [7:0] OP_RO = 8'h01;

  function automatic int cfg_bytes(input int addr_w);
    return (addr_w + 7) / 8;
  endfunction

  localparam int CFG_BYTES = cfg_bytes(DEF_ADDR_W);

  // Map order: BASE bytes, MASK bytes, one SLOT byte per window, one OP byte per window.
  function automatic int mask_off(input int num_win, input int cb);
    return num_win * cb;
  endfunction

  function automatic int slot_off(input int num_win, input int cb);
    return 2 * mask_off(num_win, cb);
  endfunction

  function automatic int op_off(input int num_win, input int cb);
    return slot_off(num_win, cb) + num_win;
  endfunction

endpackage

// File: rtl/addr_decoder_cfg_writer.sv
// rtl/addr_decoder_cfg_writer.sv - serializes window descriptors into addr_decoder cfg byte writes
module addr_decoder_cfg_writer #(
  parameter int         ADDR_W       = 32,
  parameter int         NUM_WIN      = 16,
  parameter int         NUM_SLOTS    = 5,
  parameter int         WR_GAP       = 0,
  parameter logic [7:0] IRQ_CFG_BASE = ubitz_dock_cfg_pkg::IRQ_CFG_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_win,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_mask,
  input  logic [2:0]        cmd_slot,
  input  logic [7:0]        cmd_op,
  output logic              cfg_we,
  output logic [7:0]        cfg_addr,
  output logic [7:0]        cfg_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import ubitz_dock_cfg_pkg::*;

  localparam int CB   = cfg_bytes(ADDR_W);
  localparam int DW   = 8 * CB;
  localparam int MOFF = mask_off(NUM_WIN, CB);
  localparam int SOFF = slot_off(NUM_WIN, CB);
  localparam int OOFF = op_off(NUM_WIN, CB);
  localparam bit MAP_FITS = (OOFF + NUM_WIN - 1) < int'(IRQ_CFG_BASE);
  localparam int BW = (CB > 1) ? $clog2(CB) : 1;
  localparam int GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(CB - 1);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CHECK = 4'd1;
  localparam logic [3:0] BASE  = 4'd2;
  localparam logic [3:0] MASK  = 4'd3;
  localparam logic [3:0] SLOT  = 4'd4;
  localparam logic [3:0] OP    = 4'd5;
  localparam logic [3:0] GAP   = 4'd6;
  localparam logic [3:0] DONE  = 4'd7;
  localparam logic [3:0] ERR   = 4'd8;

  logic [3:0]        state_q, state_d, ret_q, ret_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [7:0]        win_q, win_d, op_q, op_d;
  logic [ADDR_W-1:0] base_q, base_d, mask_q, mask_d;
  logic [2:0]        slot_q, slot_d;
  logic              we_q, we_d, live_q;
  logic [7:0]        addr_q, addr_d, wdata_q, wdata_d;

  logic              issue;
  logic [3:0]        iss_st, nxt_st;
  logic [BW-1:0]     iss_b, nxt_b;
  int                win_i, b_i;

  assign win_i = int'(win_q);
  assign b_i   = int'(iss_b);

  // State names a write that is on the bus this cycle; GAP parks the next one in ret_q/byte_q.
  always_comb begin
    state_d = state_q;  ret_d  = ret_q;   byte_d = byte_q;  gap_d  = gap_q;
    win_d   = win_q;    base_d = base_q;  mask_d = mask_q;  slot_d = slot_q;  op_d = op_q;
    we_d    = 1'b0;     addr_d = addr_q;  wdata_d = wdata_q;
    issue   = 1'b0;     iss_st = BASE;    iss_b  = '0;
    nxt_st  = DONE;     nxt_b  = '0;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        state_d = CHECK;
        win_d = cmd_win;  base_d = cmd_base;  mask_d = cmd_mask;
        slot_d = cmd_slot;  op_d = cmd_op;
      end
      CHECK: begin
        if (win_i >= NUM_WIN || int'(slot_q) >= NUM_SLOTS || !MAP_FITS) state_d = ERR;
        else issue = 1'b1;
      end
      BASE, MASK, SLOT, OP: begin
        if ((state_q == BASE || state_q == MASK) && byte_q != LAST_B) begin
          nxt_st = state_q;
          nxt_b  = byte_q + 1'b1;
        end else begin
          case (state_q)
            BASE:    nxt_st = MASK;
            MASK:    nxt_st = SLOT;
            SLOT:    nxt_st = OP;
            default: nxt_st = DONE;
          endcase
        end
        if (WR_GAP == 0) begin
          if (nxt_st == DONE) state_d = DONE;
          else begin issue = 1'b1; iss_st = nxt_st; iss_b = nxt_b; end
        end else begin
          state_d = GAP;  ret_d = nxt_st;  byte_d = nxt_b;  gap_d = GW'(WR_GAP - 1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (ret_q == DONE) state_d = DONE;
          else begin issue = 1'b1; iss_st = ret_q; iss_b = byte_q; end
        end else gap_d = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d = iss_st;
      byte_d  = iss_b;
      we_d    = 1'b1;
      case (iss_st)
        BASE: begin
          addr_d  = 8'(win_i * CB + b_i);
          wdata_d = 8'(DW'(base_q) >> (8 * b_i));
        end
        MASK: begin
          addr_d  = 8'(MOFF + win_i * CB + b_i);
          wdata_d = 8'(DW'(mask_q) >> (8 * b_i));
        end
        SLOT: begin
          addr_d  = 8'(SOFF + win_i);
          wdata_d = {5'b0, slot_q};
        end
        default: begin
          addr_d  = 8'(OOFF + win_i);
          wdata_d = op_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;  ret_q  <= IDLE;  byte_q <= '0;  gap_q <= '0;
      win_q   <= '0;    base_q <= '0;    mask_q <= '0;  slot_q <= '0;  op_q <= '0;
      we_q    <= 1'b0;  addr_q <= '0;    wdata_q <= '0; live_q <= 1'b0;
    end else begin
      state_q <= state_d;  ret_q  <= ret_d;   byte_q <= byte_d;  gap_q <= gap_d;
      win_q   <= win_d;    base_q <= base_d;  mask_q <= mask_d;  slot_q <= slot_d;  op_q <= op_d;
      we_q    <= we_d;     addr_q <= addr_d;  wdata_q <= wdata_d; live_q <= 1'b1;
    end
  end

  assign cmd_ready = live_q && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign cfg_we    = we_q;
  assign cfg_addr  = addr_q;
  assign cfg_wdata = wdata_q;

endmodule
